genesis_pad_reader: RTL

Scans one Mega Drive 3/6-button gamepad over the DB9 GPIO pins by driving the SELECT line through the standard 8-phase sequence. It assembles an active-high 12-bit button bitmap in the joystick layout used by the top level (`ZYXM SCBA UDLR`, bits 11:0). One instance per pad sits directly upstream of the `joystick_0`/`joystick_1` assignments, where its output is OR'd with the switch and key inputs. The update is atomic, once per poll frame.

---
 rtl/genpad_pkg.sv | 38 +++
 rtl/genpad_sync.sv | 23 ++
 rtl/genesis_pad_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/genpad_pkg.sv
// Shared types and bit positions for the Mega Drive pad reader.
package genpad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    // pad_in pin positions (active-low DB9 lines)
    localparam int PIN_UP    = 0;
    localparam int PIN_DOWN  = 1;
    localparam int PIN_LEFT  = 2;
    localparam int PIN_RIGHT = 3;
    localparam int PIN_TL    = 4;
    localparam int PIN_TR    = 5;

    // joy bit positions, ZYXM SCBA UDLR
    localparam int J_R = 0;
    localparam int J_L = 1;
    localparam int J_D = 2;
    localparam int J_U = 3;
    localparam int J_A = 4;
    localparam int J_B = 5;
    localparam int J_C = 6;
    localparam int J_S = 7;
    localparam int J_M = 8;
    localparam int J_X = 9;
    localparam int J_Y = 10;
    localparam int J_Z = 11;

    localparam int PH_READ_DPAD = 0;
    localparam int PH_READ_AS   = 1;
    localparam int PH_DETECT6   = 5;
    localparam int PH_READ_XYZM = 6;
    localparam int PH_LAST      = 7;

endpackage

// File: rtl/genpad_sync.sv
// Two-flop synchronizer for the raw pad pins; resets to all-ones because idle pins float high.
module genpad_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/genesis_pad_reader.sv
// Steps SELECT through the pad read sequence and publishes a 12-bit button map once per poll frame.
// GENPAD_SIX_BUTTON_EN: full 8-phase sequence with 6-button detection; otherwise phases 0-1 only.
module genesis_pad_reader
    import genpad_pkg::*;
#(
    parameter int STEP_CYCLES = 500,
    parameter int POLL_CYCLES = 833333
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  pad_in,
    output logic        pad_sel,
    output logic [11:0] joy,
    output logic        pad_present,
    output logic        six_button,
    output logic        joy_valid
);

    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

`ifdef GENPAD_SIX_BUTTON_EN
    localparam int PH_W     = 3;
    localparam int PH_END_I = PH_LAST;
`else
    localparam int PH_W     = 1;
    localparam int PH_END_I = PH_READ_AS;
`endif

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_END    = PH_W'(PH_END_I);

    logic [5:0]        s;
    logic [5:0]        p;
    state_t            state;
    state_t            state_nxt;
    logic [POLL_W-1:0] poll_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_nxt;
    logic              poll_last;
    logic              step_last;
    logic              capture;
    logic [11:0]       sh_btn;
    logic              sh_present;
    logic              sh_six;

    genpad_sync #(.WIDTH(6)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad_in),
        .q       (s)
    );

    assign p         = ~s;
    assign poll_last = (poll_cnt == POLL_LAST);
    assign step_last = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (poll_last) begin
                    state_nxt = STEP;
                    phase_nxt = '0;
                end
            end
            STEP: begin
                if (step_last) begin
                    capture = 1'b1;
                    if (phase == PH_END) begin
                        state_nxt = DONE;
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // Poll counter free-runs through the frame so frame spacing is exactly POLL_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt  <= '0;
            step_cnt  <= '0;
            phase     <= '0;
            pad_sel   <= 1'b1;
            joy_valid <= 1'b0;
        end else begin
            poll_cnt  <= poll_last ? '0 : poll_cnt + 1'b1;
            step_cnt  <= (state == STEP && !step_last) ? step_cnt + 1'b1 : '0;
            phase     <= phase_nxt;
            pad_sel   <= (state_nxt == STEP) ? ~phase_nxt[0] : 1'b1;
            joy_valid <= (state == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_btn     <= '0;
            sh_present <= 1'b0;
            sh_six     <= 1'b0;
        end else if (capture) begin
            if (phase == PH_W'(PH_READ_DPAD)) begin
                sh_btn[J_U] <= p[PIN_UP];
                sh_btn[J_D] <= p[PIN_DOWN];
                sh_btn[J_L] <= p[PIN_LEFT];
                sh_btn[J_R] <= p[PIN_RIGHT];
                sh_btn[J_B] <= p[PIN_TL];
                sh_btn[J_C] <= p[PIN_TR];
            end
            if (phase == PH_W'(PH_READ_AS)) begin
                sh_btn[J_A] <= p[PIN_TL];
                sh_btn[J_S] <= p[PIN_TR];
                // With SELECT low a connected pad grounds LEFT and RIGHT.
                sh_present  <= !s[PIN_LEFT] && !s[PIN_RIGHT];
            end
`ifdef GENPAD_SIX_BUTTON_EN
            if (phase == PH_W'(PH_DETECT6)) begin
                sh_six <= (s[3:0] == 4'b0000);
            end
            if (phase == PH_W'(PH_READ_XYZM) && sh_six) begin
                sh_btn[J_Z] <= p[PIN_UP];
                sh_btn[J_Y] <= p[PIN_DOWN];
                sh_btn[J_X] <= p[PIN_LEFT];
                sh_btn[J_M] <= p[PIN_RIGHT];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy         <= '0;
            pad_present <= 1'b0;
            six_button  <= 1'b0;
        end else if (state == DONE) begin
            joy         <= sh_present ? {(sh_six ? sh_btn[11:8] : 4'b0000), sh_btn[7:0]} : 12'h000;
            pad_present <= sh_present;
            six_button  <= sh_present && sh_six;
        end
    end

endmodule
